fft_2ndr_feed: RTL and testbench

//  Reader for the 2nd (column) FFT pass of the 128x128 rigid-MC transform. Starts on the fft_2ndR_config pulse raised when the
//  1st-round row results fill the four ROI BRAMs (row-major, addr = row*128+col, bank = addr[13:12]). Reads the BRAMs column by

---
 rtl/fft_mc_pkg.sv | 21 ++
 rtl/fft_feed_fifo.sv | 57 +++++
 rtl/fft_2ndr_feed.sv | 185 ++++++++++++++++++
 tb/tb_fft_2ndr_feed.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mc_pkg.sv
// Shared constants for the 128x128 rigid-MC transform: frame geometry, feed FSM states, FFT config words.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft_mc_pkg;
   localparam int N_LOG2    = 7;
   localparam int N         = 1 << N_LOG2;
   localparam int FRAME_LEN = N * N;
   localparam int NUM_BANKS = 4;
   localparam int CNT_W     = 2 * N_LOG2;      // frame sample index width
   localparam int BANK_AW   = 2 * N_LOG2 - 2;  // bank-local address width

   // Forward-transform config word for the downstream FFT core
   localparam logic [15:0] CFG_FWD = 16'h0001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CFG   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } feed_state_e;
endpackage

// File: rtl/fft_feed_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned BRAM words with their tlast flag.
// Latency: push visible at head_dat_o the cycle after the push; pop takes effect on the next edge.
// Backpressure: pushes while full are dropped (the caller's credit rule prevents them); pops while empty are ignored.
// Ports: clk_i/rst_i (sync, active-high); push_i/push_dat_i write side; pop_i/head_dat_o/empty_o read side; count_o occupancy.
module fft_feed_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_dat_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_dat_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   // A full FIFO still accepts a push when the head is leaving the same cycle
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
endmodule

// File: rtl/fft_2ndr_feed.sv
// Column-pass reader: walks the four row-major ROI BRAMs in column-major order and streams 16384 samples over AXIS.
// Latency: start in cycle 0 -> first read cycle 1 -> first tvalid cycle 2+BRAM_LAT; then 1 beat/cycle while tready is high.
// Backpressure: reads issue only while FIFO occupancy plus in-flight reads is below FIFO_DEPTH, so tready stalls never lose data.
// Ports: s_axi_aclk/s_axi_areset (sync, active-high); fft_2ndR_config start pulse; roi_bram_{0..3}_rden/rdaddr/rddata
//        bank read ports; fft_data_* AXIS master; feed_busy level, feed_done one-cycle pulse on the final accepted beat.
// Optional macro FFT_2NDR_CFG_CHAN_EN adds fft_config_valid/ready/data and a CFG state that sends CFG_FWD before reading.
module fft_2ndr_feed
   import fft_mc_pkg::*;
#(
   parameter int BRAM_LAT   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 64
) (
   input  logic               s_axi_aclk,
   input  logic               s_axi_areset,
   input  logic               fft_2ndR_config,
   output logic               roi_bram_0_rden,
   output logic [11:0]        roi_bram_0_rdaddr,
   input  logic [DATA_W-1:0]  roi_bram_0_rddata,
   output logic               roi_bram_1_rden,
   output logic [11:0]        roi_bram_1_rdaddr,
   input  logic [DATA_W-1:0]  roi_bram_1_rddata,
   output logic               roi_bram_2_rden,
   output logic [11:0]        roi_bram_2_rdaddr,
   input  logic [DATA_W-1:0]  roi_bram_2_rddata,
   output logic               roi_bram_3_rden,
   output logic [11:0]        roi_bram_3_rdaddr,
   input  logic [DATA_W-1:0]  roi_bram_3_rddata,
   input  logic               fft_data_ready,
   output logic               fft_data_valid,
   output logic               fft_data_last,
   output logic [DATA_W-1:0]  fft_data_data,
   output logic               feed_busy,
`ifdef FFT_2NDR_CFG_CHAN_EN
   output logic               fft_config_valid,
   input  logic               fft_config_ready,
   output logic [15:0]        fft_config_data,
`endif
   output logic               feed_done
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + BRAM_LAT + 1);
   localparam int FW = DATA_W + 1;

   feed_state_e         state_q;
   logic [CNT_W-1:0]    rd_cnt_q, out_cnt_q;
   logic [BRAM_LAT-1:0] vld_pipe_q, last_pipe_q;
   logic [1:0]          bank_pipe_q [BRAM_LAT];

   logic [N_LOG2-1:0]   col, row;
   logic [1:0]          bank;
   logic [BANK_AW-1:0]  rdaddr;
   logic                issue, pop, frame_end;
   logic [OW-1:0]       occupancy;
   logic [CW-1:0]       fifo_count;
   logic                fifo_empty;
   logic [DATA_W-1:0]   ret_dat;
   logic [FW-1:0]       head;

   // Row runs fastest so consecutive reads walk down one column of the row-major frame
   assign col    = rd_cnt_q[CNT_W-1:N_LOG2];
   assign row    = rd_cnt_q[N_LOG2-1:0];
   assign bank   = row[N_LOG2-1:N_LOG2-2];
   assign rdaddr = {row[N_LOG2-3:0], col};

   // Credits: every issued read owns a FIFO slot from issue until it is popped
   always_comb begin
      occupancy = OW'(fifo_count);
      for (int i = 0; i < BRAM_LAT; i++) occupancy = occupancy + OW'(vld_pipe_q[i]);
   end

   assign issue = (state_q == S_RUN) && (occupancy < OW'(FIFO_DEPTH));

   assign roi_bram_0_rden   = issue && (bank == 2'd0);
   assign roi_bram_1_rden   = issue && (bank == 2'd1);
   assign roi_bram_2_rden   = issue && (bank == 2'd2);
   assign roi_bram_3_rden   = issue && (bank == 2'd3);
   assign roi_bram_0_rdaddr = rdaddr;
   assign roi_bram_1_rdaddr = rdaddr;
   assign roi_bram_2_rdaddr = rdaddr;
   assign roi_bram_3_rdaddr = rdaddr;

   // Bank select and tlast travel alongside the read so the returning word can be steered and tagged
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         for (int i = 0; i < BRAM_LAT; i++) bank_pipe_q[i] <= '0;
      end else begin
         vld_pipe_q[0]  <= issue;
         last_pipe_q[0] <= issue && (row == N_LOG2'(N - 1));
         bank_pipe_q[0] <= bank;
         for (int i = 1; i < BRAM_LAT; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            last_pipe_q[i] <= last_pipe_q[i-1];
            bank_pipe_q[i] <= bank_pipe_q[i-1];
         end
      end
   end

   always_comb begin
      case (bank_pipe_q[BRAM_LAT-1])
         2'd0:    ret_dat = roi_bram_0_rddata;
         2'd1:    ret_dat = roi_bram_1_rddata;
         2'd2:    ret_dat = roi_bram_2_rddata;
         default: ret_dat = roi_bram_3_rddata;
      endcase
   end

   fft_feed_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (s_axi_aclk),
      .rst_i      (s_axi_areset),
      .push_i     (vld_pipe_q[BRAM_LAT-1]),
      .push_dat_i ({last_pipe_q[BRAM_LAT-1], ret_dat}),
      .pop_i      (pop),
      .head_dat_o (head),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign fft_data_valid = !fifo_empty;
   assign fft_data_data  = head[DATA_W-1:0];
   assign fft_data_last  = head[DATA_W];
   assign pop            = !fifo_empty && fft_data_ready;

   // Final beat can only leave in DRAIN: the last read needs BRAM_LAT cycles to reach the FIFO
   assign frame_end = (state_q == S_DRAIN) && pop && (out_cnt_q == CNT_W'(FRAME_LEN - 1));
   assign feed_done = frame_end;
   assign feed_busy = (state_q != S_IDLE);

`ifdef FFT_2NDR_CFG_CHAN_EN
   logic        cfg_vld_q;
   logic [15:0] cfg_dat_q;
   assign fft_config_valid = cfg_vld_q;
   assign fft_config_data  = cfg_dat_q;
`endif

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state_q   <= S_IDLE;
         rd_cnt_q  <= '0;
         out_cnt_q <= '0;
`ifdef FFT_2NDR_CFG_CHAN_EN
         cfg_vld_q <= 1'b0;
         cfg_dat_q <= '0;
`endif
      end else begin
         // Both counters wrap to 0 at the frame end, ready for the next frame
         if (issue) rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
         if (pop)   out_cnt_q <= out_cnt_q + CNT_W'(1);
         case (state_q)
            S_IDLE: begin
               if (fft_2ndR_config) begin
`ifdef FFT_2NDR_CFG_CHAN_EN
                  state_q   <= S_CFG;
                  cfg_vld_q <= 1'b1;
                  cfg_dat_q <= CFG_FWD;
`else
                  state_q   <= S_RUN;
`endif
               end
            end
`ifdef FFT_2NDR_CFG_CHAN_EN
            S_CFG: begin
               if (cfg_vld_q && fft_config_ready) begin
                  state_q   <= S_RUN;
                  cfg_vld_q <= 1'b0;
                  cfg_dat_q <= '0;
               end
            end
`endif
            S_RUN: begin
               if (issue && (rd_cnt_q == CNT_W'(FRAME_LEN - 1))) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (frame_end) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_2ndr_feed.sv
`timescale 1ns/1ps
module tb_fft_2ndr_feed;
   localparam int FIFO_DEPTH = 4;
   localparam int FRAME      = 16384;
`ifdef FFT_2NDR_CFG_CHAN_EN
   localparam int CFG_EXTRA = 1;
`else
   localparam int CFG_EXTRA = 0;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset = 1'b1;
   logic        start  = 1'b0;
   logic        ready  = 1'b0;
   logic [3:0]  rden;
   logic [11:0] rdaddr [4];
   logic [63:0] rddata [4];
   logic        vld, lst, busy, done;
   logic [63:0] dat;
`ifdef FFT_2NDR_CFG_CHAN_EN
   logic        cfg_vld;
   logic        cfg_rdy = 1'b1;
   logic [15:0] cfg_dat;
`endif

   fft_2ndr_feed dut (
      .s_axi_aclk        (clk),
      .s_axi_areset      (areset),
      .fft_2ndR_config   (start),
      .roi_bram_0_rden   (rden[0]),
      .roi_bram_0_rdaddr (rdaddr[0]),
      .roi_bram_0_rddata (rddata[0]),
      .roi_bram_1_rden   (rden[1]),
      .roi_bram_1_rdaddr (rdaddr[1]),
      .roi_bram_1_rddata (rddata[1]),
      .roi_bram_2_rden   (rden[2]),
      .roi_bram_2_rdaddr (rdaddr[2]),
      .roi_bram_2_rddata (rddata[2]),
      .roi_bram_3_rden   (rden[3]),
      .roi_bram_3_rdaddr (rdaddr[3]),
      .roi_bram_3_rddata (rddata[3]),
      .fft_data_ready    (ready),
      .fft_data_valid    (vld),
      .fft_data_last     (lst),
      .fft_data_data     (dat),
      .feed_busy         (busy),
`ifdef FFT_2NDR_CFG_CHAN_EN
      .fft_config_valid  (cfg_vld),
      .fft_config_ready  (cfg_rdy),
      .fft_config_data   (cfg_dat),
`endif
      .feed_done         (done)
   );

   // Contents of global frame address a (row-major, a = row*128+col); both halves carry the address
   function automatic logic [63:0] word(input int a);
      logic [13:0] a14;
      a14 = 14'(a);
      return {2'b00, a14, 16'h5A5A, 18'd0, a14};
   endfunction

   // Reference model of the column-major stream: out beat i reads row i%128 of column i/128
   function automatic int exp_addr(input int i);
      return (i % 128) * 128 + (i / 128);
   endfunction

   // Four BRAM banks with two cycles of read latency; bank k holds global addresses k*4096 .. k*4096+4095
   logic [63:0] pipe1 [4];
   logic [63:0] pipe2 [4];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         pipe1[k] <= rden[k] ? word(k * 4096 + int'(rdaddr[k])) : 64'hDEAD_BEEF_DEAD_BEEF;
         pipe2[k] <= pipe1[k];
      end
   end
   always_comb for (int k = 0; k < 4; k++) rddata[k] = pipe2[k];

   // Passive observer: records accepted beats and tallies protocol observations for the tasks to judge
   int          cyc = 0, hs_cnt = 0, iss_cnt = 0, done_cnt = 0, done_beat = -1, done_cyc = -1;
   int          stab_err = 0, ovf_err = 0, hot_err = 0, addr_err = 0, outstanding = 0;
   logic [63:0] cap_dat [$];
   logic        cap_last [$];
   logic        pend = 1'b0, pend_last = 1'b0;
   logic [63:0] pend_dat = '0;

   always @(negedge clk) begin
      cyc++;
      if (pend && !areset && (!vld || dat !== pend_dat || lst !== pend_last)) stab_err++;
      if (!areset && (|rden) && outstanding >= FIFO_DEPTH) ovf_err++;
      if ($countones(rden) > 1) hot_err++;
      if (rdaddr[0] !== rdaddr[1] || rdaddr[0] !== rdaddr[2] || rdaddr[0] !== rdaddr[3]) addr_err++;
      if (|rden) iss_cnt++;
      if (vld && ready) begin
         hs_cnt++;
         cap_dat.push_back(dat);
         cap_last.push_back(lst);
      end
      if (done) begin
         done_cnt++;
         done_beat = hs_cnt - 1;
         done_cyc  = cyc;
      end
      if (areset) outstanding = 0;
      else outstanding = outstanding + int'(|rden) - int'(vld && ready);
      pend      = vld && !ready && !areset;
      pend_dat  = dat;
      pend_last = lst;
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic test_reset();
      areset = 1'b1;
      start  = 1'b0;
      ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({rden, vld, lst, busy, done} !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 00000000", {rden, vld, lst, busy, done});
      end
      n_chk++;
      if (dat !== 64'd0 || rdaddr[0] !== 12'd0 || rdaddr[3] !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_data: data=%h addr0=%h addr3=%h want 0", dat, rdaddr[0], rdaddr[3]);
      end
`ifdef FFT_2NDR_CFG_CHAN_EN
      n_chk++;
      if (cfg_vld !== 1'b0 || cfg_dat !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_cfg: valid=%b data=%h want 0/0000", cfg_vld, cfg_dat);
      end
`endif
      areset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (busy !== 1'b0 || |rden) begin
         n_bad++;
         $display("FAIL idle_after_reset: busy=%b rden=%b want 0/0000", busy, rden);
      end
   endtask

   // Ready held high; checks latency, no bubbles, stream order, tlast, done, and a start on the done cycle
   task automatic test_full_frame();
      int b_hs, b_iss, b_done, b_q, c0, first_rd, first_vld, err, first_bad, t;
      logic busy1;
      b_hs = hs_cnt; b_iss = iss_cnt; b_done = done_cnt; b_q = cap_dat.size();
      first_rd = -1; first_vld = -1; busy1 = 1'b0;
      ready = 1'b1;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      c0 = cyc;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = busy;
         if (first_rd < 0 && |rden) first_rd = c;
         if (first_vld < 0 && vld) first_vld = c;
         @(posedge clk); #1;
      end
      n_chk++;
      if (busy1 !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b want 1", busy1); end
      n_chk++;
      if (first_rd != 1 + CFG_EXTRA) begin
         n_bad++; $display("FAIL first_rden_cycle: got %0d want %0d", first_rd, 1 + CFG_EXTRA);
      end
      n_chk++;
      if (first_vld != 4 + CFG_EXTRA) begin
         n_bad++; $display("FAIL first_valid_cycle: got %0d want %0d", first_vld, 4 + CFG_EXTRA);
      end
      t = 0;
      while (!done && t < 20000) begin @(negedge clk); t++; end
      if (!done) begin
         n_chk++; n_bad++;
         $display("FAIL full_timeout: beats=%0d want %0d", hs_cnt - b_hs, FRAME);
      end else begin
         start = 1'b1;    // lands on the done cycle, while still DRAIN: must be ignored
         @(posedge clk); #1; start = 1'b0;
         n_chk++;
         if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b want 0", busy); end
      end
      repeat (30) @(posedge clk);
      #1;
      n_chk++;
      if (done_cyc - c0 != 4 + CFG_EXTRA + FRAME - 1) begin
         n_bad++; $display("FAIL done_cycle: got %0d want %0d", done_cyc - c0, 4 + CFG_EXTRA + FRAME - 1);
      end
      n_chk++;
      if (hs_cnt - b_hs != FRAME || iss_cnt - b_iss != FRAME) begin
         n_bad++; $display("FAIL full_counts: beats=%0d reads=%0d want %0d", hs_cnt - b_hs, iss_cnt - b_iss, FRAME);
      end
      n_chk++;
      if (done_cnt - b_done != 1 || done_beat - b_hs != FRAME - 1) begin
         n_bad++; $display("FAIL full_done: count=%0d at_beat=%0d want 1/%0d", done_cnt - b_done, done_beat - b_hs, FRAME - 1);
      end
      err = 0; first_bad = -1;
      for (int i = 0; i < FRAME; i++) begin
         if (b_q + i >= cap_dat.size() || cap_dat[b_q + i] !== word(exp_addr(i)) || cap_last[b_q + i] !== ((i % 128) == 127)) begin
            err++; if (first_bad < 0) first_bad = i;
         end
      end
      n_chk++;
      if (err != 0) begin n_bad++; $display("FAIL full_stream: %0d bad beats, first at %0d, want 0", err, first_bad); end
      n_chk++;
      if (busy !== 1'b0 || vld !== 1'b0) begin n_bad++; $display("FAIL full_idle: busy=%b valid=%b want 0/0", busy, vld); end
   endtask

   // 50-cycle stall inside column 3, then a stray start at beat 5000
   task automatic test_stall_restart();
      int b_hs, b_iss, b_done, b_q, b_stab, b_ovf, t, stall_hs, outst, err, first_bad;
      logic vld_end;
      b_hs = hs_cnt; b_iss = iss_cnt; b_done = done_cnt; b_q = cap_dat.size(); b_stab = stab_err; b_ovf = ovf_err;
      ready = 1'b1;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t = 0;
      while (hs_cnt - b_hs < 3 * 128 + 40 && t < 2000) begin @(posedge clk); #1; t++; end
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      stall_hs = hs_cnt;
      repeat (50) @(posedge clk);
      #1;
      outst = (iss_cnt - b_iss) - (hs_cnt - b_hs);
      vld_end = vld;
      n_chk++;
      if (hs_cnt != stall_hs || vld_end !== 1'b1) begin
         n_bad++; $display("FAIL stall_hold: beats_during=%0d valid=%b want 0/1", hs_cnt - stall_hs, vld_end);
      end
      n_chk++;
      if (outst != FIFO_DEPTH) begin n_bad++; $display("FAIL stall_outstanding: got %0d want %0d", outst, FIFO_DEPTH); end
      ready = 1'b1;
      t = 0;
      while (hs_cnt - b_hs < 5000 && t < 20000) begin @(posedge clk); #1; t++; end
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t = 0;
      while (hs_cnt - b_hs < FRAME && t < 20000) begin @(posedge clk); #1; t++; end
      repeat (30) @(posedge clk);
      #1;
      n_chk++;
      if (stab_err != b_stab) begin n_bad++; $display("FAIL stall_stability: %0d unstable cycles want 0", stab_err - b_stab); end
      n_chk++;
      if (ovf_err != b_ovf) begin n_bad++; $display("FAIL stall_credit: %0d over-issues want 0", ovf_err - b_ovf); end
      n_chk++;
      if (hs_cnt - b_hs != FRAME || iss_cnt - b_iss != FRAME || done_cnt - b_done != 1) begin
         n_bad++;
         $display("FAIL restart_ignored: beats=%0d reads=%0d dones=%0d want %0d/%0d/1", hs_cnt - b_hs, iss_cnt - b_iss, done_cnt - b_done, FRAME, FRAME);
      end
      err = 0; first_bad = -1;
      for (int i = 0; i < FRAME; i++) begin
         if (b_q + i >= cap_dat.size() || cap_dat[b_q + i] !== word(exp_addr(i)) || cap_last[b_q + i] !== ((i % 128) == 127)) begin
            err++; if (first_bad < 0) first_bad = i;
         end
      end
      n_chk++;
      if (err != 0) begin n_bad++; $display("FAIL stall_stream: %0d bad beats, first at %0d, want 0", err, first_bad); end
   endtask

   // Reset at beat 9000: outputs clear at once, nothing stale follows
   task automatic test_reset_midframe();
      int b_hs, b_done, t, r_hs, r_iss;
      b_hs = hs_cnt; b_done = done_cnt;
      ready = 1'b1;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t = 0;
      while (hs_cnt - b_hs < 9000 && t < 20000) begin @(posedge clk); #1; t++; end
      areset = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if ({rden, vld, lst, busy, done} !== 8'd0 || dat !== 64'd0 || rdaddr[0] !== 12'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs: ctrl=%b data=%h addr=%h want 0", {rden, vld, lst, busy, done}, dat, rdaddr[0]);
      end
      areset = 1'b0;
      r_hs = hs_cnt; r_iss = iss_cnt;
      repeat (20) @(posedge clk);
      #1;
      n_chk++;
      if (hs_cnt != r_hs || iss_cnt != r_iss || busy !== 1'b0) begin
         n_bad++; $display("FAIL midreset_stale: beats=%0d reads=%0d busy=%b want 0/0/0", hs_cnt - r_hs, iss_cnt - r_iss, busy);
      end
      n_chk++;
      if (done_cnt != b_done) begin n_bad++; $display("FAIL midreset_done: got %0d want 0", done_cnt - b_done); end
   endtask

   // Fresh frame with 50% random tready
   task automatic test_random_ready();
      int b_hs, b_iss, b_done, b_q, b_stab, b_ovf, b_hot, b_addr, t, err, first_bad;
      b_hs = hs_cnt; b_iss = iss_cnt; b_done = done_cnt; b_q = cap_dat.size();
      b_stab = stab_err; b_ovf = ovf_err; b_hot = hot_err; b_addr = addr_err;
      ready = 1'b0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t = 0;
      while (hs_cnt - b_hs < FRAME && t < 80000) begin
         ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1; t++;
      end
      ready = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_chk++;
      if (hs_cnt - b_hs != FRAME || iss_cnt - b_iss != FRAME) begin
         n_bad++; $display("FAIL rand_counts: beats=%0d reads=%0d want %0d", hs_cnt - b_hs, iss_cnt - b_iss, FRAME);
      end
      n_chk++;
      if (done_cnt - b_done != 1 || done_beat - b_hs != FRAME - 1) begin
         n_bad++; $display("FAIL rand_done: count=%0d at_beat=%0d want 1/%0d", done_cnt - b_done, done_beat - b_hs, FRAME - 1);
      end
      n_chk++;
      if (ovf_err != b_ovf || stab_err != b_stab) begin
         n_bad++; $display("FAIL rand_protocol: over_issue=%0d unstable=%0d want 0/0", ovf_err - b_ovf, stab_err - b_stab);
      end
      n_chk++;
      if (hot_err != b_hot || addr_err != b_addr) begin
         n_bad++; $display("FAIL rand_rden_onehot: multi=%0d addr_diff=%0d want 0/0", hot_err - b_hot, addr_err - b_addr);
      end
      err = 0; first_bad = -1;
      for (int i = 0; i < FRAME; i++) begin
         if (b_q + i >= cap_dat.size() || cap_dat[b_q + i] !== word(exp_addr(i)) || cap_last[b_q + i] !== ((i % 128) == 127)) begin
            err++; if (first_bad < 0) first_bad = i;
         end
      end
      n_chk++;
      if (err != 0) begin n_bad++; $display("FAIL rand_stream: %0d bad beats, first at %0d, want 0", err, first_bad); end
   endtask

`ifdef FFT_2NDR_CFG_CHAN_EN
   // Config handshake delayed 10 cycles: word held, no reads until accepted
   task automatic test_cfg_chan();
      int held, early;
      logic rd_after, vld_after;
      held = 0; early = 0;
      cfg_rdy = 1'b0; ready = 1'b1;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (cfg_vld === 1'b1 && cfg_dat === 16'h0001) held++;
         if (|rden) early++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (held != 10 || early != 0) begin
         n_bad++; $display("FAIL cfg_hold: held=%0d early_reads=%0d want 10/0", held, early);
      end
      cfg_rdy = 1'b1;
      @(posedge clk); #1; cfg_rdy = 1'b0;
      @(negedge clk);
      rd_after = |rden; vld_after = cfg_vld;
      n_chk++;
      if (rd_after !== 1'b1 || vld_after !== 1'b0) begin
         n_bad++; $display("FAIL cfg_to_run: rden=%b cfg_valid=%b want 1/0", rd_after, vld_after);
      end
      areset = 1'b1;
      @(posedge clk); #1; areset = 1'b0;
      cfg_rdy = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_stall_restart();
      test_reset_midframe();
      test_random_ready();
`ifdef FFT_2NDR_CFG_CHAN_EN
      test_cfg_chan();
`endif
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
